// File: rtl/hex_cmd_pkg.sv
// Shared types and ASCII constants for the hex command parser.
package hex_cmd_pkg;

    typedef enum logic [2:0] {
        IDLE,
        ADDR,
        DATA,
        EOL,
        CMD,
        SKIP
    } state_e;

    typedef enum logic {
        OP_READ  = 1'b0,
        OP_WRITE = 1'b1
    } op_e;

    localparam logic [7:0] ASCII_CR = 8'h0D;
    localparam logic [7:0] ASCII_LF = 8'h0A;
    localparam logic [7:0] ASCII_SP = 8'h20;
    localparam logic [7:0] ASCII_W  = 8'h57;
    localparam logic [7:0] ASCII_R  = 8'h52;

    // Clearing bit 5 folds lowercase letters onto uppercase.
    function automatic logic is_letter(input logic [7:0] ch, input logic [7:0] upper);
        return (ch & 8'hDF) == upper;
    endfunction

    function automatic logic is_eol(input logic [7:0] ch);
        return (ch == ASCII_CR) || (ch == ASCII_LF);
    endfunction

endpackage

// File: rtl/hex_cmd_parser_dec.sv
// ASCII hex digit decoder: maps 0-9, A-F, a-f onto a nibble.
module hex_char_dec (
    input  logic [7:0] ch,
    output logic [3:0] nibble,
    output logic       is_hex
);

    always_comb begin
        nibble = 4'h0;
        is_hex = 1'b0;
        unique case (1'b1)
            (ch >= 8'h30 && ch <= 8'h39): begin
                nibble = ch[3:0];
                is_hex = 1'b1;
            end
            (ch >= 8'h41 && ch <= 8'h46),
            (ch >= 8'h61 && ch <= 8'h66): begin
                nibble = ch[3:0] + 4'd9;
                is_hex = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/hex_cmd_parser.sv
// Parses ASCII "W<addr><data>" / "R<addr>" lines into read/write commands.
module hex_cmd_parser
    import hex_cmd_pkg::*;
#(
    parameter int ADDR_DIGITS = 2,
    parameter int DATA_DIGITS = 4
) (
    input  logic                     CLK,
    input  logic                     RST,
    input  logic                     iVALID,
    input  logic [7:0]               iD,
    output logic                     oREADY,
    output logic                     oCMD_VALID,
    input  logic                     iCMD_READY,
    output logic                     oWE,
    output logic [4*ADDR_DIGITS-1:0] oADDR,
    output logic [4*DATA_DIGITS-1:0] oWDATA,
    output logic                     oERR
);

    localparam int AW   = 4 * ADDR_DIGITS;
    localparam int DW   = 4 * DATA_DIGITS;
    localparam int MAXD = (ADDR_DIGITS > DATA_DIGITS) ? ADDR_DIGITS : DATA_DIGITS;
    localparam int CW   = $clog2(MAXD + 1);

    state_e        state_q, state_d;
    op_e           op_q, op_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [DW-1:0] data_q, data_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          err_q, err_d;

    logic [3:0] nib;
    logic       is_hex;
    logic       accept;
    logic       eol;

    hex_char_dec u_dec (
        .ch     (iD),
        .nibble (nib),
        .is_hex (is_hex)
    );

    assign accept = iVALID && (state_q != CMD);
    assign eol    = is_eol(iD);

    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        addr_d  = addr_q;
        data_d  = data_q;
        cnt_d   = cnt_q;
        err_d   = 1'b0;
        unique case (state_q)
            IDLE: if (accept) begin
                if (is_letter(iD, ASCII_W) || is_letter(iD, ASCII_R)) begin
                    op_d    = is_letter(iD, ASCII_W) ? OP_WRITE : OP_READ;
                    addr_d  = '0;
                    data_d  = '0;
                    cnt_d   = '0;
                    state_d = ADDR;
                end else if (!eol && iD != ASCII_SP) begin
                    err_d   = 1'b1;
                    state_d = SKIP;
                end
            end
            ADDR: if (accept) begin
                if (is_hex) begin
                    addr_d = AW'({addr_q, nib});
                    if (cnt_q == CW'(ADDR_DIGITS - 1)) begin
                        cnt_d   = '0;
                        data_d  = '0;
                        state_d = (op_q == OP_WRITE) ? DATA : EOL;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end else begin
                    err_d   = 1'b1;
                    state_d = SKIP;
                end
            end
            DATA: if (accept) begin
                if (is_hex) begin
                    data_d = DW'({data_q, nib});
                    if (cnt_q == CW'(DATA_DIGITS - 1)) begin
                        cnt_d   = '0;
                        state_d = EOL;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end else begin
                    err_d   = 1'b1;
                    state_d = SKIP;
                end
            end
            EOL: if (accept) begin
                if (eol) begin
                    state_d = CMD;
                end else begin
                    err_d   = 1'b1;
                    state_d = SKIP;
                end
            end
            CMD: if (iCMD_READY) begin
                state_d = IDLE;
            end
            SKIP: if (accept && eol) begin
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= IDLE;
            op_q    <= OP_READ;
            addr_q  <= '0;
            data_q  <= '0;
            cnt_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
        end
    end

    assign oREADY     = (state_q != CMD);
    assign oCMD_VALID = (state_q == CMD);
    assign oWE        = (op_q == OP_WRITE);
    assign oADDR      = addr_q;
    assign oWDATA     = data_q;
    assign oERR       = err_q;

endmodule

// File: tb/tb_hex_cmd_parser.sv
// Bench for hex_cmd_parser: line-grammar model plus directed byte strings.
module tb_hex_cmd_parser;

    localparam int AD = 2;
    localparam int DD = 4;

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic        iVALID = 1'b0;
    logic [7:0]  iD = 8'h00;
    logic        iCMD_READY = 1'b1;
    logic        oREADY, oCMD_VALID, oWE, oERR;
    logic [7:0]  oADDR;
    logic [15:0] oWDATA;

    int vectors = 0;
    int miscompares = 0;
    bit chk_en = 1'b0;

    always #5 CLK = ~CLK;

    hex_cmd_parser #(.ADDR_DIGITS(AD), .DATA_DIGITS(DD)) dut (
        .CLK        (CLK),
        .RST        (RST),
        .iVALID     (iVALID),
        .iD         (iD),
        .oREADY     (oREADY),
        .oCMD_VALID (oCMD_VALID),
        .iCMD_READY (iCMD_READY),
        .oWE        (oWE),
        .oADDR      (oADDR),
        .oWDATA     (oWDATA),
        .oERR       (oERR)
    );

    function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h, want %0h (t=%0t)", name, act, exp, $time);
        end
    endfunction

    // Model: accepted bytes collected as a line and judged against the grammar
    byte unsigned line[$];
    bit          skipping = 0;
    bit          m_cmd = 0, m_err = 0, m_we = 0;
    logic [7:0]  m_addr = 0;
    logic [15:0] m_wdata = 0;
    int          m_cmds = 0, m_errs = 0;

    function automatic int hexval(byte unsigned b);
        if (b >= "0" && b <= "9") return int'(b) - 48;
        if (b >= "a" && b <= "f") return int'(b) - 87;
        if (b >= "A" && b <= "F") return int'(b) - 55;
        return -1;
    endfunction

    function automatic bit is_term(byte unsigned b);
        return b == 8'h0D || b == 8'h0A;
    endfunction

    function automatic void flag_err();
        m_err = 1;
        m_errs++;
        skipping = 1;
        line.delete();
    endfunction

    function automatic void consume(byte unsigned b);
        bit wr;
        int need;
        if (skipping) begin
            if (is_term(b)) skipping = 0;
            return;
        end
        if (line.size() == 0) begin
            if (is_term(b) || b == 8'h20) return;
            if (b inside {"W", "w", "R", "r"}) line.push_back(b);
            else flag_err();
            return;
        end
        wr = (line[0] == "W") || (line[0] == "w");
        need = 1 + AD + (wr ? DD : 0);
        if (line.size() < need) begin
            if (hexval(b) >= 0) line.push_back(b);
            else flag_err();
            return;
        end
        if (!is_term(b)) begin
            flag_err();
            return;
        end
        m_we = wr;
        m_addr = 0;
        m_wdata = 0;
        for (int i = 1; i <= AD; i++) m_addr = 8'(m_addr * 16 + hexval(line[i]));
        if (wr)
            for (int i = 0; i < DD; i++) m_wdata = 16'(m_wdata * 16 + hexval(line[1 + AD + i]));
        m_cmd = 1;
        m_cmds++;
        line.delete();
    endfunction

    always @(posedge CLK) begin
        m_err = 0;
        if (RST) begin
            line.delete();
            skipping = 0;
            m_cmd = 0;
            m_we = 0;
            m_addr = 0;
            m_wdata = 0;
        end else if (m_cmd) begin
            if (iCMD_READY) m_cmd = 0;
        end else if (iVALID) begin
            consume(iD);
        end
    end

    // Per-cycle compare and observed-command log
    bit          prev_v = 0;
    int          dut_cmds = 0, dut_errs = 0;
    logic        d_we = 0;
    logic [7:0]  d_addr = 0;
    logic [15:0] d_wdata = 0;

    always @(negedge CLK) begin
        if (chk_en) begin
            chk("ready", oREADY, !m_cmd);
            chk("cmd_valid", oCMD_VALID, m_cmd);
            chk("err", oERR, m_err);
            if (m_cmd) begin
                chk("we", oWE, m_we);
                chk("addr", oADDR, m_addr);
                chk("wdata", oWDATA, m_wdata);
            end
            if (oCMD_VALID && !prev_v) begin
                dut_cmds++;
                d_we = oWE;
                d_addr = oADDR;
                d_wdata = oWDATA;
            end
            if (oERR) dut_errs++;
            prev_v = oCMD_VALID;
        end
    end

    task automatic send_byte(byte unsigned b);
        int n = 0;
        iVALID = 1'b1;
        iD = b;
        while (!oREADY && n < 100) begin
            @(negedge CLK);
            n++;
        end
        if (!oREADY) begin
            vectors++;
            miscompares++;
            $display("FAIL send_timeout: byte %0h not accepted, oREADY=%0b want 1", b, oREADY);
        end
        @(negedge CLK);
        iVALID = 1'b0;
    endtask

    task automatic send_str(string s);
        for (int i = 0; i < s.len(); i++) send_byte(s[i]);
    endtask

    task automatic stage(string nm, int cmds, int errs, logic we, logic [7:0] a, logic [15:0] w);
        repeat (3) @(negedge CLK);
        chk({nm, "_cmds"}, dut_cmds, cmds);
        chk({nm, "_errs"}, dut_errs, errs);
        chk({nm, "_model_cmds"}, m_cmds, cmds);
        chk({nm, "_model_errs"}, m_errs, errs);
        chk({nm, "_we"}, d_we, we);
        chk({nm, "_addr"}, d_addr, a);
        chk({nm, "_wdata"}, d_wdata, w);
    endtask

    initial begin
        RST = 1'b1;
        repeat (2) @(negedge CLK);
        RST = 1'b0;
        chk("rst_ready", oREADY, 1);
        chk("rst_valid", oCMD_VALID, 0);
        chk("rst_we", oWE, 0);
        chk("rst_addr", oADDR, 0);
        chk("rst_wdata", oWDATA, 0);
        chk("rst_err", oERR, 0);
        chk_en = 1'b1;
        @(negedge CLK);
        chk("post_rst_ready", oREADY, 1);

        send_str("W1A00FF"); send_byte(8'h0D);
        stage("w1a", 1, 0, 1'b1, 8'h1A, 16'h00FF);

        send_str("r3c"); send_byte(8'h0A);
        stage("r3c", 2, 0, 1'b0, 8'h3C, 16'h0000);

        send_str("wabcdef"); send_byte(8'h0D);
        stage("lower", 3, 0, 1'b1, 8'hAB, 16'hCDEF);

        send_str("W1G2345"); send_byte(8'h0D);
        send_str("R05"); send_byte(8'h0D);
        stage("bad_hex", 4, 1, 1'b0, 8'h05, 16'h0000);

        send_str("R123"); send_byte(8'h0D);
        stage("long_rd", 4, 2, 1'b0, 8'h05, 16'h0000);

        send_byte(8'h0D); send_str(" X "); send_byte(8'h0A);
        stage("idle_junk", 4, 3, 1'b0, 8'h05, 16'h0000);

        iCMD_READY = 1'b0;
        send_str("W1234AB"); send_byte(8'h0D);
        for (int k = 0; k < 5; k++) begin
            chk("hold_ready", oREADY, 0);
            chk("hold_valid", oCMD_VALID, 1);
            chk("hold_addr", oADDR, 8'h12);
            chk("hold_wdata", oWDATA, 16'h34AB);
            @(negedge CLK);
        end
        iCMD_READY = 1'b1;
        @(negedge CLK);
        chk("release_ready", oREADY, 1);
        chk("release_valid", oCMD_VALID, 0);
        stage("hold", 5, 3, 1'b1, 8'h12, 16'h34AB);

        send_str("W12");
        RST = 1'b1;
        @(negedge CLK);
        RST = 1'b0;
        chk("mid_rst_ready", oREADY, 1);
        chk("mid_rst_valid", oCMD_VALID, 0);
        chk("mid_rst_we", oWE, 0);
        chk("mid_rst_addr", oADDR, 0);
        chk("mid_rst_wdata", oWDATA, 0);
        chk("mid_rst_err", oERR, 0);
        send_str("R05"); send_byte(8'h0D);
        stage("after_rst", 6, 3, 1'b0, 8'h05, 16'h0000);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
